// File: rtl/sync_fifo_rd_stream_if.sv
// Valid/ready stream carrying words read out of a sync_fifo, with burst framing.
interface sync_fifo_rd_stream_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;

   modport master (
      output m_data,
      output m_valid,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_valid,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/sync_fifo_rd_stream.sv
// Read-side adapter for a non-lookahead sync_fifo: issues rd_en, catches the word
// one clock later into a 2-entry skid buffer and presents it on a valid/ready
// stream. Frames fixed-length bursts with m_last and counts accepted words.
module sync_fifo_rd_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclr,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   sync_fifo_rd_stream_if.master m,
   output logic [CNT_WIDTH-1:0]  xfer_cnt
);

   // Burst index is 16 bits wide so that any legal BURST_LEN (1..65535) fits.
   localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

   logic [DATA_WIDTH-1:0] buf_mem_r [2];
   logic                  head_r;
   logic                  tail_r;
   logic [1:0]            buf_count_r;
   logic                  inflight_r;
   logic [15:0]           burst_idx_r;
   logic [CNT_WIDTH-1:0]  xfer_cnt_r;

   logic                  valid_s;
   logic                  pop_s;
   logic                  push_s;
   logic                  rd_en_s;
   logic [2:0]            occ_after_pop_s;
   logic [1:0]            buf_count_nxt_s;
   logic                  head_nxt_s;
   logic                  tail_nxt_s;
   logic [15:0]           burst_idx_nxt_s;

   // Handshake decode and read-issue decision: a read is only issued when the
   // word it returns is guaranteed a free buffer slot, counting the word already
   // in flight and the slot freed by this cycle's pop.
   always_comb begin
      valid_s         = (buf_count_r != 2'd0);
      pop_s           = valid_s & m.m_ready;
      push_s          = inflight_r;
      occ_after_pop_s = {1'b0, buf_count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
      rd_en_s         = rst & ~sclr & ~fifo_empty & (occ_after_pop_s < 3'd2);
   end

   // Next-state for buffer occupancy, pointers and burst position.
   always_comb begin
      buf_count_nxt_s = buf_count_r;
      case ({push_s, pop_s})
         2'b10:   buf_count_nxt_s = buf_count_r + 2'd1;
         2'b01:   buf_count_nxt_s = buf_count_r - 2'd1;
         default: buf_count_nxt_s = buf_count_r;
      endcase

      if (pop_s) begin
         head_nxt_s = ~head_r;
      end else begin
         head_nxt_s = head_r;
      end

      if (push_s) begin
         tail_nxt_s = ~tail_r;
      end else begin
         tail_nxt_s = tail_r;
      end

      if (!pop_s) begin
         burst_idx_nxt_s = burst_idx_r;
      end else if (burst_idx_r == LAST_IDX) begin
         burst_idx_nxt_s = 16'd0;
      end else begin
         burst_idx_nxt_s = burst_idx_r + 16'd1;
      end
   end

   // Skid buffer storage, pointers, occupancy and in-flight tracking; sclr also
   // drops the word returning from a read issued the cycle before.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_mem_r[0] <= {DATA_WIDTH{1'b0}};
         buf_mem_r[1] <= {DATA_WIDTH{1'b0}};
         head_r       <= 1'b0;
         tail_r       <= 1'b0;
         buf_count_r  <= 2'd0;
         inflight_r   <= 1'b0;
      end else if (sclr) begin
         head_r       <= 1'b0;
         tail_r       <= 1'b0;
         buf_count_r  <= 2'd0;
         inflight_r   <= 1'b0;
      end else begin
         if (push_s) begin
            buf_mem_r[tail_r] <= fifo_data_out;
         end
         head_r       <= head_nxt_s;
         tail_r       <= tail_nxt_s;
         buf_count_r  <= buf_count_nxt_s;
         inflight_r   <= rd_en_s;
      end
   end

   // Position within the current burst; restarts on sclr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         burst_idx_r <= 16'd0;
      end else if (sclr) begin
         burst_idx_r <= 16'd0;
      end else begin
         burst_idx_r <= burst_idx_nxt_s;
      end
   end

   // Accepted-word counter; only the asynchronous reset clears it, it wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xfer_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (pop_s) begin
         xfer_cnt_r <= xfer_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         xfer_cnt_r <= xfer_cnt_r;
      end
   end

   assign fifo_rd_en = rd_en_s;
   assign m.m_valid  = valid_s;
   assign m.m_data   = buf_mem_r[head_r];
   assign m.m_last   = valid_s & (burst_idx_r == LAST_IDX);
   assign xfer_cnt   = xfer_cnt_r;

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Bench for sync_fifo_rd_stream: two instances (default framing, and a short
// burst / narrow counter) each fed by a behavioural non-lookahead FIFO, checked
// against an ordered-word scoreboard plus occupancy bookkeeping.
module tb_sync_fifo_rd_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        rst_nxt;
   logic        sclr;
   logic        m_ready;
   logic        wr0, wr1;
   logic [31:0] wd0, wd1;
   logic [31:0] fdo0, fdo1;
   logic        fe0, fe1;
   logic        rd0, rd1;
   logic [15:0] xc0;
   logic [3:0]  xc1;

   sync_fifo_rd_stream_if #(.DATA_WIDTH(32)) s0 ();
   sync_fifo_rd_stream_if #(.DATA_WIDTH(32)) s1 ();
   assign s0.m_ready = m_ready;
   assign s1.m_ready = m_ready;

   sync_fifo_rd_stream #(.DATA_WIDTH(32), .BURST_LEN(16), .CNT_WIDTH(16)) dut0 (
      .clk(clk), .rst(rst), .sclr(sclr), .fifo_data_out(fdo0), .fifo_empty(fe0),
      .fifo_rd_en(rd0), .m(s0), .xfer_cnt(xc0));

   sync_fifo_rd_stream #(.DATA_WIDTH(32), .BURST_LEN(3), .CNT_WIDTH(4)) dut1 (
      .clk(clk), .rst(rst), .sclr(sclr), .fifo_data_out(fdo1), .fifo_empty(fe1),
      .fifo_rd_en(rd1), .m(s1), .xfer_cnt(xc1));

   // Behavioural sync_fifo, LOOKAHEAD=0: data_out appears the clock after rd_en.
   logic [31:0] fq0[$];
   logic [31:0] fq1[$];
   int fc0 = 0;
   int fc1 = 0;
   assign fe0 = (fc0 == 0);
   assign fe1 = (fc1 == 0);

   always @(posedge clk) begin
      if (sclr) begin
         fq0.delete();
         fq1.delete();
         fc0 <= 0;
         fc1 <= 0;
      end else begin
         if (rd0) fdo0 <= fq0.pop_front();
         if (wr0) fq0.push_back(wd0);
         fc0 <= fc0 + int'(wr0) - int'(rd0);
         if (rd1) fdo1 <= fq1.pop_front();
         if (wr1) fq1.push_back(wd1);
         fc1 <= fc1 + int'(wr1) - int'(rd1);
      end
   end

   // Reference model: words expected in order, and per-unit bookkeeping of
   // words held by the adapter (outstanding reads) and of accepted words.
   logic [31:0] exp0[$];
   logic [31:0] exp1[$];
   int          out_m    [2];
   int          infl_m   [2];
   int          burst_m  [2];
   int          popped_m [2];
   bit          stall_m  [2];
   logic [31:0] hold_m   [2];

   int n_cmp = 0;
   int n_bad = 0;
   int mode  = 0;
   int pat   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic unit_check(input int u, input logic v, input logic [31:0] d, input logic l,
                             input logic rd, input logic fe, input logic [15:0] xc,
                             input logic [31:0] head, output bit pop_o);
      int          bl;
      logic [15:0] msk;
      bit          exp_rd;
      bl     = (u == 0) ? 16 : 3;
      msk    = (u == 0) ? 16'hFFFF : 16'h000F;
      pop_o  = v & m_ready;
      exp_rd = rst & ~sclr & ~fe & ((out_m[u] - int'(pop_o)) < 2);
      chk($sformatf("u%0d_valid", u), 64'(v), 64'((out_m[u] - infl_m[u]) > 0));
      chk($sformatf("u%0d_rd_en", u), 64'(rd), 64'(exp_rd));
      chk($sformatf("u%0d_xfer_cnt", u), 64'(xc), 64'(16'(popped_m[u]) & msk));
      chk($sformatf("u%0d_last", u), 64'(l), 64'(v && (burst_m[u] == bl - 1)));
      if (!rst) chk($sformatf("u%0d_rst_data", u), 64'(d), 64'd0);
      if (pop_o) chk($sformatf("u%0d_data", u), 64'(d), 64'(head));
      if (stall_m[u]) begin
         chk($sformatf("u%0d_hold_valid", u), 64'(v), 64'd1);
         chk($sformatf("u%0d_hold_data", u), 64'(d), 64'(hold_m[u]));
      end
      stall_m[u] = v & ~m_ready & ~sclr;
      hold_m[u]  = d;
      if (sclr) begin
         if (pop_o) popped_m[u]++;
         out_m[u]   = 0;
         infl_m[u]  = 0;
         burst_m[u] = 0;
      end else begin
         if (pop_o) begin
            popped_m[u]++;
            burst_m[u] = (burst_m[u] + 1) % bl;
            out_m[u]--;
         end
         if (rd) out_m[u]++;
         infl_m[u] = int'(rd);
      end
   endtask

   // One clock: drive inputs at the falling edge, check outputs, advance the model.
   task automatic step(input bit w0, input logic [31:0] d0, input bit w1,
                       input logic [31:0] d1, input bit clr);
      bit          p0, p1;
      logic [31:0] h0, h1;
      @(negedge clk);
      rst  = rst_nxt;
      sclr = clr;
      wr0  = w0; wd0 = d0;
      wr1  = w1; wd1 = d1;
      case (mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
         2:       m_ready = 1'($urandom_range(0, 1));
         default: m_ready = 1'b1;
      endcase
      if (clr) m_ready = 1'b0;
      pat++;
      #1;
      h0 = (exp0.size() != 0) ? exp0[0] : 32'hDEAD_BEEF;
      h1 = (exp1.size() != 0) ? exp1[0] : 32'hDEAD_BEEF;
      unit_check(0, s0.m_valid, s0.m_data, s0.m_last, rd0, fe0, xc0, h0, p0);
      unit_check(1, s1.m_valid, s1.m_data, s1.m_last, rd1, fe1, {12'h000, xc1}, h1, p1);
      if (p0 && exp0.size() != 0) void'(exp0.pop_front());
      if (p1 && exp1.size() != 0) void'(exp1.pop_front());
      if (clr) begin
         exp0.delete();
         exp1.delete();
      end else begin
         if (w0) exp0.push_back(d0);
         if (w1) exp1.push_back(d1);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp0.size() != 0 || exp1.size() != 0 || out_m[0] != 0 || out_m[1] != 0) && k < 400) begin
         step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
         k++;
      end
      chk("drain_left", 64'(exp0.size() + exp1.size() + out_m[0] + out_m[1]), 64'd0);
   endtask

   initial begin
      int          vcount;
      int          k;
      logic [2:0]  vseq;
      logic [15:0] xsave;
      for (int u = 0; u < 2; u++) begin
         out_m[u] = 0; infl_m[u] = 0; burst_m[u] = 0; popped_m[u] = 0;
         stall_m[u] = 1'b0; hold_m[u] = 32'd0;
      end
      rst = 1'b0; rst_nxt = 1'b0; sclr = 1'b0; m_ready = 1'b1;
      wr0 = 1'b0; wr1 = 1'b0; wd0 = 32'd0; wd1 = 32'd0;

      // Reset held while the FIFO fills with 0x1..0x10: adapter must stay idle.
      mode = 0;
      for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("rst_rd_en", 64'(rd0), 64'd0);
      chk("rst_valid", 64'(s0.m_valid), 64'd0);

      // Release reset: m_valid first seen after the second rising edge.
      rst_nxt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
         vseq[i] = s0.m_valid;
      end
      chk("first_valid_latency", 64'(vseq), 64'b100);

      // Full-rate stream of the 16 prefetched words.
      vcount = 1;
      k = 0;
      while (exp0.size() != 0 && k < 60) begin
         step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
         if (s0.m_valid) vcount++;
         k++;
      end
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("stream_valid_cycles", 64'(vcount), 64'd16);
      chk("stream_xfer_cnt", 64'(xc0), 64'd16);

      // Backpressure with ready pattern 1,0,0,1.
      mode = 1; pat = 0;
      for (int i = 0; i < 16; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 32'd0, 1'b0);
      drain();
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("bp_xfer_cnt", 64'(xc0), 64'd32);

      // FIFO runs empty mid-burst; burst position carries across the gap.
      mode = 0;
      for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 32'd0, 1'b0);
      repeat (20) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      for (int i = 5; i < 16; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 32'd0, 1'b0);
      drain();
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("gap_xfer_cnt", 64'(xc0), 64'd48);
      chk("gap_burst_idx", 64'(burst_m[0]), 64'd0);

      // sclr in steady streaming (one word buffered, one in flight).
      mode = 0;
      for (int i = 0; i < 8; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 32'd0, 1'b0);
      k = 0;
      while (!(infl_m[0] == 1 && out_m[0] == 2) && k < 20) begin
         step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
         k++;
      end
      chk("sclr_setup_infl", 64'(infl_m[0]), 64'd1);
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      chk("sclr_cycle_rd_en", 64'(rd0), 64'd0);
      xsave = xc0;
      step(1'b1, 32'h0000_00AB, 1'b0, 32'd0, 1'b0);
      chk("sclr_valid_after", 64'(s0.m_valid), 64'd0);
      chk("sclr_xfer_kept", 64'(xc0), 64'(xsave));
      drain();
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("sclr_one_word_out", 64'(xc0), 64'(xsave + 16'd1));

      // Random ready and write gaps; unit 1 sees 18 words (BURST_LEN=3, CNT_WIDTH=4).
      mode = 2;
      for (int i = 0; i < 18; i++) begin
         while ($urandom_range(0, 2) == 0) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
         step(1'($urandom_range(0, 1)), $urandom, 1'b1, 32'h400 + 32'(i), 1'b0);
      end
      drain();
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("wrap_xfer_cnt", 64'(xc1), 64'd2);
      chk("wrap_burst_idx", 64'(burst_m[1]), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
